// File: rtl/biquad_cascade_pkg.sv
// rtl/biquad_cascade_pkg.sv - shared settings addresses, FSM encodings and coefficient indices
package biquad_cascade_pkg;

  // Settings-bus register addresses
  localparam logic [6:0] FR_MRFM_IIR_COEFF = 7'd80;
  localparam logic [6:0] FR_MRFM_IIR_SHIFT = 7'd81;
  localparam logic [6:0] FR_MRFM_IIR_CTRL  = 7'd82;
  localparam logic [6:0] FR_MRFM_DEBUG     = 7'd83;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MAC   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  // Coefficient order within a stage; feedback taps are stored pre-negated
  localparam logic [2:0] K_B0 = 3'd0;
  localparam logic [2:0] K_B1 = 3'd1;
  localparam logic [2:0] K_B2 = 3'd2;
  localparam logic [2:0] K_A1 = 3'd3;
  localparam logic [2:0] K_A2 = 3'd4;

  // Flat coefficient RAM index for a stage/tap pair
  function automatic logic [7:0] coeff_index(input logic [2:0] stage, input logic [2:0] k);
    return ({5'b0, stage} * 8'd5) + {5'b0, k};
  endfunction

endpackage

// File: rtl/biquad_cascade_mac.sv
// rtl/biquad_cascade_mac.sv - shared registered multiplier, accumulator and output field select (BIQUAD_CASCADE_SAT_EN enables saturation)
module biquad_cascade_mac #(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int PROD_W      = DATA_WIDTH + COEFF_WIDTH - 1,
  parameter int ACC_W       = PROD_W + 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          op_valid,
  input  logic signed [COEFF_WIDTH-1:0] coeff,
  input  logic signed [DATA_WIDTH-1:0]  data,
  input  logic                          clear,
  input  logic        [7:0]             shift,
  output logic signed [ACC_W-1:0]       acc,
  output logic signed [DATA_WIDTH-1:0]  y
);

  localparam int FULL_W = DATA_WIDTH + COEFF_WIDTH;

  logic signed [PROD_W-1:0] product;
  logic                     prod_valid;

  // Registered multiplier: one product per issued operand pair
  always_ff @(posedge clock) begin
    if (reset) begin
      product    <= '0;
      prod_valid <= 1'b0;
    end else begin
      product    <= PROD_W'(FULL_W'(coeff) * FULL_W'(data));
      prod_valid <= op_valid;
    end
  end

  // Accumulator: cleared between stages, adds only valid products
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      acc <= '0;
    end else if (prod_valid) begin
      acc <= acc + ACC_W'(product);
    end
  end

`ifdef BIQUAD_CASCADE_SAT_EN
  logic signed [ACC_W-1:0]          shifted;
  logic        [ACC_W-DATA_WIDTH:0] upper;

  assign shifted = acc >>> shift;
  assign upper   = shifted[ACC_W-1:DATA_WIDTH-1];

  // Saturate when the bits above the field are not pure sign copies
  always_comb begin
    if ((&upper) || !(|upper)) begin
      y = shifted[DATA_WIDTH-1:0];
    end else if (acc[ACC_W-1]) begin
      y = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      y = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end
`else
  // Plain field select; wraps on overflow
  assign y = DATA_WIDTH'(acc >>> shift);
`endif

endmodule

// File: rtl/biquad_cascade.sv
// rtl/biquad_cascade.sv - time-multiplexed DF-I biquad cascade (BIQUAD_CASCADE_SAT_EN enables output saturation)
module biquad_cascade
  import biquad_cascade_pkg::*;
#(
  parameter int NUM_STAGES  = 2,
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  serial_strobe,
  input  logic [6:0]            serial_addr,
  input  logic [31:0]           serial_data,
  input  logic                  strobe_in,
  input  logic [DATA_WIDTH-1:0] sample_in,
  output logic                  strobe_out,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  busy,
  output logic                  overrun,
  output logic [63:0]           debugbus
);

  localparam int         PROD_W      = DATA_WIDTH + COEFF_WIDTH - 1;
  localparam int         ACC_W       = PROD_W + 3;
  localparam int         NUM_COEFFS  = 5 * NUM_STAGES;
  localparam int         IDX_W       = $clog2(NUM_COEFFS);
  localparam int         ST_W        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [7:0] NUM_COEFFS_B = 8'(NUM_COEFFS);
  localparam logic [7:0] MAX_SHIFT   = 8'(ACC_W - DATA_WIDTH);
  localparam logic [2:0] LAST_STAGE  = 3'(NUM_STAGES - 1);

  logic signed [COEFF_WIDTH-1:0] coeff_ram [NUM_COEFFS];
  logic        [7:0]             shift_reg [NUM_STAGES];
  logic signed [DATA_WIDTH-1:0]  x1 [NUM_STAGES];
  logic signed [DATA_WIDTH-1:0]  x2 [NUM_STAGES];
  logic signed [DATA_WIDTH-1:0]  y1 [NUM_STAGES];
  logic signed [DATA_WIDTH-1:0]  y2 [NUM_STAGES];

  state_t                        state;
  logic        [2:0]             stage;
  logic        [2:0]             k;
  logic                          drain_cnt;
  logic signed [DATA_WIDTH-1:0]  x_cur;
  logic        [1:0]             debug_sel;

  logic signed [COEFF_WIDTH-1:0] op_coeff;
  logic signed [DATA_WIDTH-1:0]  op_data;
  logic                          op_valid;
  logic signed [ACC_W-1:0]       acc;
  logic signed [DATA_WIDTH-1:0]  y;

  logic        [ST_W-1:0]        si;
  logic        [7:0]             wr_index;
  logic        [2:0]             wr_stage;
  logic        [7:0]             wr_shift;
  logic                          coeff_wr;
  logic                          shift_wr;
  logic                          unused_bits;

  assign si          = ST_W'(stage);
  assign wr_index    = serial_data[23:16];
  assign wr_stage    = serial_data[10:8];
  assign wr_shift    = (serial_data[7:0] > MAX_SHIFT) ? MAX_SHIFT : serial_data[7:0];
  assign coeff_wr    = serial_strobe && (serial_addr == FR_MRFM_IIR_COEFF) && (wr_index < NUM_COEFFS_B);
  assign shift_wr    = serial_strobe && (serial_addr == FR_MRFM_IIR_SHIFT) &&
                       ({1'b0, wr_stage} < 4'(NUM_STAGES));
  assign unused_bits = ^serial_data[31:24];

  // Coefficient RAM: software-loaded, deliberately kept across reset
  always_ff @(posedge clock) begin
    if (coeff_wr) begin
      coeff_ram[IDX_W'(wr_index)] <= COEFF_WIDTH'($signed(serial_data[15:0]));
    end
  end

  // Sequencer, history, settings registers and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      stage      <= '0;
      k          <= K_B0;
      drain_cnt  <= 1'b0;
      x_cur      <= '0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      strobe_out <= 1'b0;
      sample_out <= '0;
      debug_sel  <= '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        shift_reg[i] <= '0;
        x1[i]        <= '0;
        x2[i]        <= '0;
        y1[i]        <= '0;
        y2[i]        <= '0;
      end
    end else begin
      strobe_out <= 1'b0;

      if (shift_wr) begin
        shift_reg[ST_W'(wr_stage)] <= wr_shift;
      end
      if (serial_strobe && (serial_addr == FR_MRFM_DEBUG)) begin
        debug_sel <= serial_data[1:0];
      end
      if (serial_strobe && (serial_addr == FR_MRFM_IIR_CTRL)) begin
        overrun <= 1'b0;
      end
      // A sample arriving mid-pass is dropped; only the sticky flag records it
      if (strobe_in && (state != ST_IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (strobe_in) begin
            x_cur <= sample_in;
            stage <= '0;
            k     <= K_B0;
            busy  <= 1'b1;
            state <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (k == K_A2) begin
            k         <= K_B0;
            drain_cnt <= 1'b0;
            state     <= ST_DRAIN;
          end else begin
            k <= k + 3'd1;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt) begin
            state <= ST_WRITE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        ST_WRITE: begin
          x2[si] <= x1[si];
          x1[si] <= x_cur;
          y2[si] <= y1[si];
          y1[si] <= y;
          x_cur  <= y;
          if (stage == LAST_STAGE) begin
            sample_out <= y;
            strobe_out <= 1'b1;
            state      <= ST_OUT;
          end else begin
            stage <= stage + 3'd1;
            state <= ST_MAC;
          end
        end
        ST_OUT: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Operand fetch: one-cycle registered read of coefficient and history
  always_ff @(posedge clock) begin
    if (reset) begin
      op_valid <= 1'b0;
      op_coeff <= '0;
      op_data  <= '0;
    end else begin
      op_valid <= (state == ST_MAC);
      op_coeff <= coeff_ram[IDX_W'(coeff_index(stage, k))];
      case (k)
        K_B0:    op_data <= x_cur;
        K_B1:    op_data <= x1[si];
        K_B2:    op_data <= x2[si];
        K_A1:    op_data <= y1[si];
        default: op_data <= y2[si];
      endcase
    end
  end

  biquad_cascade_mac #(
    .DATA_WIDTH  (DATA_WIDTH),
    .COEFF_WIDTH (COEFF_WIDTH),
    .PROD_W      (PROD_W),
    .ACC_W       (ACC_W)
  ) u_mac (
    .clock    (clock),
    .reset    (reset),
    .op_valid (op_valid),
    .coeff    (op_coeff),
    .data     (op_data),
    .clear    (state == ST_WRITE),
    .shift    (shift_reg[si]),
    .acc      (acc),
    .y        (y)
  );

  // Debug view selected by the debug settings register
  always_comb begin
    debugbus = '0;
    case (debug_sel)
      2'd0: debugbus = {16'(x_cur), 16'(sample_out), 16'h0000,
                        3'b000, state, stage, k, busy, overrun, strobe_out, op_valid};
      2'd1: debugbus = 64'(acc);
      2'd2: debugbus = {16'(op_coeff), 16'(op_data), 16'(y), 8'h00, shift_reg[si]};
      default: debugbus = {16'(x1[si]), 16'(x2[si]), 16'(y1[si]), 16'(y2[si])};
    endcase
  end

endmodule
